cfeb_tap_responder: RTL and testbench

Synthesizable IEEE 1149.1 TAP responder for the CFEB JTAG chain: it receives TCK/TMS/TDI from the DMB CFEB JTAG master and returns TDO. It runs entirely in the FASTCLK domain, oversampling TCK. It provides a CFEB-side target for loopback/self-test builds and for bench verification of the master. It exposes a user data register so that words shifted by the master appear in parallel, and parallel capture data is shifted back out.

---
 rtl/cfeb_tap_responder.sv | 177 +++++++++++++++++
 tb/tb_cfeb_tap_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfeb_tap_responder.sv
// IEEE 1149.1 TAP responder for the CFEB JTAG chain, oversampling TCK in the FASTCLK domain.
// Define CFEB_TAP_IDCODE_EN to include the 32-bit IDCODE register (reset instruction IDCODE).
module cfeb_tap_responder #(
  parameter int unsigned IR_WIDTH   = 5,
  parameter int unsigned DR_WIDTH   = 16,
  parameter logic [31:0] IDCODE_VAL = 32'h0CFEB093
) (
  input  logic                FASTCLK,
  input  logic                RST_B,
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  input  logic [DR_WIDTH-1:0] CAP_DATA,
  output logic                TDO,
  output logic                TDO_OE,
  output logic [3:0]          TAP_STATE,
  output logic [IR_WIDTH-1:0] IR_OUT,
  output logic [DR_WIDTH-1:0] USER_OUT,
  output logic                UPDATE
);

  typedef enum logic [3:0] {
    S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR  = 4'h2, S_PAUDR = 4'h3,
    S_SELIR = 4'h4, S_UPDDR = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7,
    S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR  = 4'hA, S_PAUIR = 4'hB,
    S_RTI   = 4'hC, S_UPDIR = 4'hD, S_CAPIR = 4'hE, S_TLR   = 4'hF
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef CFEB_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] RESET_IR   = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_IR   = '1;
`endif

  if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_check
    $error("IDCODE_VAL bit 0 must be 1");
  end

  logic r_tck_s1, r_tck_s2, r_tck_d, r_tck_rise, r_tck_fall;
  logic r_tms_s1, r_tms_s2, r_tdi_s1, r_tdi_s2;

  tap_state_e          r_state, w_next;
  logic [IR_WIDTH-1:0] r_ir_sr, r_ir;
  logic [DR_WIDTH-1:0] r_user_sr, r_user_out;
  logic                r_bypass, r_tdo, r_tdo_oe, r_update;
  logic                w_sel_user, w_sel_idcode, w_sel_bypass, w_dr_lsb;
`ifdef CFEB_TAP_IDCODE_EN
  logic [31:0]         r_idcode_sr;
`endif

  // Two-flop synchronizers plus a registered edge strobe give the 4-cycle TCK-to-effect latency.
  always_ff @(posedge FASTCLK or negedge RST_B) begin
    if (!RST_B) begin
      r_tck_s1   <= 1'b0;
      r_tck_s2   <= 1'b0;
      r_tck_d    <= 1'b0;
      r_tck_rise <= 1'b0;
      r_tck_fall <= 1'b0;
      r_tms_s1   <= 1'b1;
      r_tms_s2   <= 1'b1;
      r_tdi_s1   <= 1'b0;
      r_tdi_s2   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the previous stage's old value.
      r_tck_s1   <= TCK;
      r_tck_s2   <= r_tck_s1;
      r_tck_d    <= r_tck_s2;
      r_tck_rise <= r_tck_s2 & ~r_tck_d;
      r_tck_fall <= ~r_tck_s2 & r_tck_d;
      r_tms_s1   <= TMS;
      r_tms_s2   <= r_tms_s1;
      r_tdi_s1   <= TDI;
      r_tdi_s2   <= r_tdi_s1;
    end
  end

  always_comb begin
    // NOTE: a default before the case keeps this block free of inferred latches.
    w_next = r_state;
    case (r_state)
      S_TLR:   w_next = r_tms_s2 ? S_TLR   : S_RTI;
      S_RTI:   w_next = r_tms_s2 ? S_SELDR : S_RTI;
      S_SELDR: w_next = r_tms_s2 ? S_SELIR : S_CAPDR;
      S_CAPDR: w_next = r_tms_s2 ? S_EX1DR : S_SHDR;
      S_SHDR:  w_next = r_tms_s2 ? S_EX1DR : S_SHDR;
      S_EX1DR: w_next = r_tms_s2 ? S_UPDDR : S_PAUDR;
      S_PAUDR: w_next = r_tms_s2 ? S_EX2DR : S_PAUDR;
      S_EX2DR: w_next = r_tms_s2 ? S_UPDDR : S_SHDR;
      S_UPDDR: w_next = r_tms_s2 ? S_SELDR : S_RTI;
      S_SELIR: w_next = r_tms_s2 ? S_TLR   : S_CAPIR;
      S_CAPIR: w_next = r_tms_s2 ? S_EX1IR : S_SHIR;
      S_SHIR:  w_next = r_tms_s2 ? S_EX1IR : S_SHIR;
      S_EX1IR: w_next = r_tms_s2 ? S_UPDIR : S_PAUIR;
      S_PAUIR: w_next = r_tms_s2 ? S_EX2IR : S_PAUIR;
      S_EX2IR: w_next = r_tms_s2 ? S_UPDIR : S_SHIR;
      S_UPDIR: w_next = r_tms_s2 ? S_SELDR : S_RTI;
      default: w_next = S_TLR;
    endcase
  end

  assign w_sel_user   = (r_ir == IR_USER);
`ifdef CFEB_TAP_IDCODE_EN
  assign w_sel_idcode = (r_ir == IR_IDCODE);
  assign w_dr_lsb     = w_sel_user ? r_user_sr[0] : (w_sel_idcode ? r_idcode_sr[0] : r_bypass);
`else
  assign w_sel_idcode = 1'b0;
  assign w_dr_lsb     = w_sel_user ? r_user_sr[0] : r_bypass;
`endif
  assign w_sel_bypass = ~w_sel_user & ~w_sel_idcode;

  always_ff @(posedge FASTCLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state    <= S_TLR;
      r_ir       <= RESET_IR;
      r_ir_sr    <= '0;
      r_user_sr  <= '0;
      r_user_out <= '0;
      r_bypass   <= 1'b0;
      r_tdo      <= 1'b0;
      r_tdo_oe   <= 1'b0;
      r_update   <= 1'b0;
`ifdef CFEB_TAP_IDCODE_EN
      r_idcode_sr <= '0;
`endif
    end else begin
      r_update <= 1'b0;
      if (r_tck_rise) begin
        r_state  <= w_next;
        r_tdo_oe <= (w_next == S_SHDR) || (w_next == S_SHIR);
        if (w_next == S_TLR) r_ir <= RESET_IR;
        case (r_state)
          S_CAPIR: r_ir_sr <= IR_CAPTURE;
          S_SHIR:  r_ir_sr <= {r_tdi_s2, r_ir_sr[IR_WIDTH-1:1]};
          S_CAPDR: begin
            if (w_sel_user)   r_user_sr <= CAP_DATA;
            if (w_sel_bypass) r_bypass  <= 1'b0;
`ifdef CFEB_TAP_IDCODE_EN
            if (w_sel_idcode) r_idcode_sr <= IDCODE_VAL;
`endif
          end
          S_SHDR: begin
            if (w_sel_user)   r_user_sr <= {r_tdi_s2, r_user_sr[DR_WIDTH-1:1]};
            if (w_sel_bypass) r_bypass  <= r_tdi_s2;
`ifdef CFEB_TAP_IDCODE_EN
            if (w_sel_idcode) r_idcode_sr <= {r_tdi_s2, r_idcode_sr[31:1]};
`endif
          end
          default: ;
        endcase
      end else if (r_tck_fall) begin
        case (r_state)
          S_UPDIR: r_ir <= r_ir_sr;
          S_UPDDR: begin
            if (w_sel_user) begin
              r_user_out <= r_user_sr;
              r_update   <= 1'b1;
            end
          end
          S_SHIR:  r_tdo <= r_ir_sr[0];
          S_SHDR:  r_tdo <= w_dr_lsb;
          default: ;
        endcase
      end
    end
  end

  assign TDO       = r_tdo;
  assign TDO_OE    = r_tdo_oe;
  assign TAP_STATE = r_state;
  assign IR_OUT    = r_ir;
  assign USER_OUT  = r_user_out;
  assign UPDATE    = r_update;

endmodule

// File: tb/tb_cfeb_tap_responder.sv
// Scoreboard bench for cfeb_tap_responder: a JTAG master drives scans, monitors compare TDO bits and USER_OUT updates.
// Honours CFEB_TAP_IDCODE_EN the same way as the design.
module tb_cfeb_tap_responder;
  localparam int IR_W = 5;
  localparam int DR_W = 16;
  localparam logic [31:0] IDC = 32'h0CFEB093;
`ifdef CFEB_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] RST_IR = 5'h01;
`else
  localparam logic [IR_W-1:0] RST_IR = 5'h1F;
`endif

  logic            fastclk = 1'b0;
  logic            rst_b = 1'b0;
  logic            tck = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic [DR_W-1:0] cap_data = '0;
  logic            tdo, tdo_oe, update;
  logic [3:0]      tap_state;
  logic [IR_W-1:0] ir_out;
  logic [DR_W-1:0] user_out;

  cfeb_tap_responder #(.IR_WIDTH(IR_W), .DR_WIDTH(DR_W), .IDCODE_VAL(IDC)) dut (
    .FASTCLK(fastclk), .RST_B(rst_b), .TCK(tck), .TMS(tms), .TDI(tdi),
    .CAP_DATA(cap_data), .TDO(tdo), .TDO_OE(tdo_oe), .TAP_STATE(tap_state),
    .IR_OUT(ir_out), .USER_OUT(user_out), .UPDATE(update)
  );

  always #5 fastclk = ~fastclk;

  int n_cmp = 0;
  int n_err = 0;
  bit              exp_tdo_q[$];
  logic [DR_W-1:0] exp_user_q[$];
  logic [IR_W-1:0] m_ir;
  logic [DR_W-1:0] m_user;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // TDO monitor: the master samples TDO on every TCK rise while the TAP drives it.
  always @(posedge tck) begin
    if (tdo_oe === 1'b1) begin
      if (exp_tdo_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tdo_unexpected: TDO=%b driven with no bit expected (t=%0t)", tdo, $time);
      end else begin
        check("tdo_bit", 64'(tdo), 64'(exp_tdo_q.pop_front()));
      end
    end
  end

  // UPDATE monitor: every pulse must match a pending expected USER_OUT word.
  always @(negedge fastclk) begin
    if (update === 1'b1) begin
      if (exp_user_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL update_unexpected: USER_OUT=%h pulsed with no update pending (t=%0t)", user_out, $time);
      end else begin
        check("user_out_update", 64'(user_out), 64'(exp_user_q.pop_front()));
      end
    end
  end

  initial begin
    #2ms;
    n_err++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  // Reference decode: 1 = IDCODE (when built in), 2 = USER, anything else BYPASS.
  function automatic bit is_user(input logic [IR_W-1:0] ir);
    return ir == IR_W'(2);
  endfunction

  function automatic int dr_len(input logic [IR_W-1:0] ir);
`ifdef CFEB_TAP_IDCODE_EN
    if (ir == IR_W'(1)) return 32;
`endif
    if (is_user(ir)) return DR_W;
    return 1;
  endfunction

  function automatic logic [31:0] dr_cap(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] cap);
`ifdef CFEB_TAP_IDCODE_EN
    if (ir == IR_W'(1)) return IDC;
`endif
    if (is_user(ir)) return 32'(cap);
    return 32'h0;
  endfunction

  task automatic tck_cycle(input bit t_ms, input bit t_di);
    @(negedge fastclk);
    tms = t_ms;
    tdi = t_di;
    repeat (6) @(negedge fastclk);
    tck = 1'b1;
    repeat (6) @(negedge fastclk);
    tck = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge fastclk);
  endtask

  task automatic scan_ir(input logic [IR_W-1:0] val);
    tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int k = 0; k < IR_W; k++) begin
      exp_tdo_q.push_back(k == 0);
      tck_cycle(k == IR_W - 1, val[k]);
    end
    tck_cycle(1, 0); tck_cycle(0, 0);
    m_ir = val;
    settle();
    check("ir_out_after_scan", 64'(ir_out), 64'(m_ir));
    check("state_rti_after_ir", 64'(tap_state), 64'hC);
  endtask

  // Scan n bits (LSB first) through the selected DR starting and ending in Run-Test/Idle.
  task automatic scan_dr(input int n, input logic [63:0] bits);
    int              len;
    logic [31:0]     cap;
    logic [DR_W-1:0] exp_u;
    len = dr_len(m_ir);
    cap = dr_cap(m_ir, cap_data);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int k = 0; k < n; k++) begin
      exp_tdo_q.push_back((k < len) ? cap[k] : bits[k - len]);
      tck_cycle(k == n - 1, bits[k]);
    end
    if (is_user(m_ir)) begin
      for (int j = 0; j < DR_W; j++)
        exp_u[j] = (j + n < len) ? cap[j + n] : bits[j + n - len];
      exp_user_q.push_back(exp_u);
      m_user = exp_u;
    end
    tck_cycle(1, 0); tck_cycle(0, 0);
    settle();
    check("user_out_after_dr", 64'(user_out), 64'(m_user));
    check("state_rti_after_dr", 64'(tap_state), 64'hC);
  endtask

  initial begin
    logic [IR_W-1:0] rv;
    m_ir   = RST_IR;
    m_user = '0;
    repeat (3) @(negedge fastclk);
    check("reset_state", 64'(tap_state), 64'hF);
    check("reset_ir", 64'(ir_out), 64'(RST_IR));
    check("reset_tdo", 64'(tdo), 64'h0);
    check("reset_tdo_oe", 64'(tdo_oe), 64'h0);
    check("reset_update", 64'(update), 64'h0);
    check("reset_user_out", 64'(user_out), 64'h0);
    rst_b = 1'b1;
    repeat (2) @(negedge fastclk);
    tck_cycle(0, 0);
    settle();
    check("state_rti", 64'(tap_state), 64'hC);

    // Reset halfway through a USER shift: immediate TLR, no update, nothing committed.
    scan_ir(IR_W'(2));
    cap_data = DR_W'($urandom);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int k = 0; k < 8; k++) begin
      exp_tdo_q.push_back(cap_data[k]);
      tck_cycle(0, 1'($urandom));
    end
    @(negedge fastclk);
    rst_b = 1'b0;
    #1;
    check("midshift_reset_state", 64'(tap_state), 64'hF);
    check("midshift_reset_tdo_oe", 64'(tdo_oe), 64'h0);
    check("midshift_reset_ir", 64'(ir_out), 64'(RST_IR));
    check("midshift_user_out", 64'(user_out), 64'(m_user));
    exp_tdo_q.delete();
    m_ir = RST_IR;
    repeat (8) @(negedge fastclk);
    rst_b = 1'b1;
    repeat (2) @(negedge fastclk);
    check("midshift_user_out_after", 64'(user_out), 64'(m_user));
    tck_cycle(0, 0);

    // Five TMS=1 rises from Shift-DR return to TLR; the path crosses Update-DR once.
    scan_ir(IR_W'(2));
    cap_data = DR_W'($urandom);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    exp_tdo_q.push_back(cap_data[0]);
    m_user = {1'b0, cap_data[DR_W-1:1]};
    exp_user_q.push_back(m_user);
    repeat (5) tck_cycle(1, 0);
    settle();
    check("tms_reset_state", 64'(tap_state), 64'hF);
    check("tms_reset_ir", 64'(ir_out), 64'(RST_IR));
    m_ir = RST_IR;
    tck_cycle(0, 0);

    // IDCODE (or BYPASS when IDCODE is not built) straight after TLR.
    scan_dr(32, {$urandom, $urandom});

    scan_ir(IR_W'(2));
    cap_data = DR_W'($urandom);
    scan_dr(16, 64'hA5C3);
    check("user_a5c3", 64'(user_out), 64'hA5C3);

    cap_data = 16'h1234;
    scan_dr(16, {$urandom, $urandom});

    scan_ir('1);
    scan_dr(8, 64'b10110010);

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0:       rv = IR_W'(1);
        1:       rv = IR_W'(2);
        2:       rv = '1;
        default: rv = IR_W'($urandom);
      endcase
      scan_ir(rv);
      cap_data = DR_W'($urandom);
      scan_dr($urandom_range(1, 48), {$urandom, $urandom});
    end

    check("tdo_queue_drained", 64'(exp_tdo_q.size()), 64'h0);
    check("update_queue_drained", 64'(exp_user_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
